btn_gesture: RTL and testbench
==============================

// Module: btn_gesture
// PURPOSE
//  Downstream consumer of one debounced button level. Classifies each press as
//  short, long or double-click, and emits auto-repeat ticks while a long press is held.
//  Sits between the debouncer and the counter/LED logic on the board top.
//  Gives that logic richer single-cycle events than a bare press tick.
// PARAMETERS
//  CLK_HZ     27_000_000  clock frequency; CLK_HZ/1000 cycles = 1 ms (must divide exactly)
//  LONG_MS    600         hold time that promotes a press to long (>=1)
//  DCLICK_MS  250         max gap after first release for a second press to count (>=1)
//  REPEAT_MS  100         auto-repeat period after long_tick (>=1)
// PORTS
//  clk           in   1  system clock
//  rst           in   1  synchronous reset, active-high
//  level         in   1  debounced button level, 1 = pressed
//  held          out  1  1 while in PRESS1/PRESS2/LONG_HOLD
//  short_tick    out  1  1-cycle pulse: single short press confirmed
//  long_tick     out  1  1-cycle pulse: hold reached LONG_MS
//  repeat_tick   out  1  1-cycle pulse: every REPEAT_MS while long-held
//  double_tick   out  1  1-cycle pulse: second short press released
// BEHAVIOUR
//  - Interface: one clock (clk); reset is synchronous and active-high (rst).
//  - All outputs are registered. All outputs are 0 during reset and in the cycle after it.
//  - At most one *_tick output is high in any cycle.
//  - Timer: the elapsed-ms count and the prescaler clear on every state change, and on
//    every repeat_tick. A threshold of N ms fires exactly N*CLK_HZ/1000 cycles after the
//    entry cycle.
//  - Timer width: $clog2(max(LONG_MS,DCLICK_MS,REPEAT_MS)+1). The timer saturates and
//    never wraps.
//  - States and transitions (level is sampled every cycle):
//    ARM:       reset state. level==0 -> IDLE. No press is accepted until level has been
//               seen low (a button held through reset is ignored).
//    IDLE:      level==1 -> PRESS1.
//    PRESS1:    level==0 -> GAP.
//               Timer==LONG_MS with level==1 -> LONG_HOLD, long_tick.
//    GAP:       level==1 -> PRESS2.
//               Timer==DCLICK_MS -> IDLE, short_tick. short_tick is deferred until the
//               double-click window expires.
//    PRESS2:    level==0 -> IDLE, double_tick.
//               Timer==LONG_MS -> LONG_HOLD, long_tick. The pending short and the double
//               are discarded.
//    LONG_HOLD: every REPEAT_MS -> repeat_tick and timer restart.
//               level==0 -> IDLE with no pulse.
//  - Simultaneous events: a level change in the same cycle as a threshold wins; no tick
//    fires.
//  - rst mid-operation: return to ARM. A pending short is dropped. A tick pulse due in
//    that cycle is suppressed.
//  - Pulses are asserted on the cycle after the transition condition (registered outputs).
// STRUCTURE
//  - Shared package/include board_pkg: CLK_HZ default, MS_CYCLES = CLK_HZ/1000.
//  - State encoding stays as localparams inside this module.
//  - One sub-module, ms_timer. Params CLK_HZ, W.
//    Ports: clk, rst, clr, ms_cnt[W-1:0]. Contains the prescaler and the saturating ms
//    counter.
//  - The FSM and output registers live in btn_gesture.
// TESTING  (CLK_HZ=10_000 so 1 ms = 10 cycles; LONG_MS=20, DCLICK_MS=10, REPEAT_MS=5)
//  1. Press 5 ms, then release -> exactly one short_tick, 100 cycles after GAP entry.
//     held is high during the press. No other ticks.
//  2. Hold 37 ms -> long_tick 200 cycles after PRESS1 entry, then repeat_tick at +50,
//     +100, +150. Release -> no further pulses.
//  3. Press 3 ms, gap 4 ms, press 3 ms, release -> one double_tick one cycle after the
//     second release. No short_tick.
//  4. Press 3 ms, gap 4 ms, second press held 20 ms -> one long_tick. No double_tick,
//     no short_tick.
//  5. rst pulsed during GAP -> no short_tick. With level held high across the reset
//     release: no events. Events resume only after level goes low and then high again.
//  6. Release landing exactly on the LONG_MS threshold cycle -> GAP entered, no long_tick.
//     short_tick follows 100 cycles later.

Source files
------------

// File: rtl/board_pkg.sv
// Board-wide timing constants and small elaboration-time helpers shared by the
// button-handling blocks.
package board_pkg;

    localparam int unsigned CLK_HZ    = 27_000_000;
    localparam int unsigned MS_CYCLES = CLK_HZ / 1000;

    function automatic int unsigned cycles_per_ms(input int unsigned clk_hz);
        return clk_hz / 1000;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ms_timer.sv
// Millisecond timer: a cycle prescaler feeding a saturating ms counter, both
// restarted by clr.
module ms_timer #(
    parameter int unsigned CLK_HZ = board_pkg::CLK_HZ,
    parameter int unsigned W      = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    output logic [W-1:0] ms_cnt
);
    import board_pkg::*;

    localparam int unsigned   MS         = cycles_per_ms(CLK_HZ);
    localparam int unsigned   PW         = (MS > 1) ? $clog2(MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(MS - 1);
    localparam logic [W-1:0]  MS_MAX     = '1;

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_base;
    logic [W-1:0]  ms_base;

    // The clr cycle itself counts as the first elapsed cycle, so a threshold of
    // N ms is seen exactly N ms after the cycle that requested the restart.
    always_comb begin
        presc_base = clr ? '0 : presc;
        ms_base    = clr ? '0 : ms_cnt;
    end

    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values;
    // blocking here would make results depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc  <= '0;
            ms_cnt <= '0;
        end else if (presc_base == PRESC_LAST) begin
            presc  <= '0;
            ms_cnt <= (ms_base == MS_MAX) ? ms_base : ms_base + 1'b1;
        end else begin
            presc  <= presc_base + 1'b1;
            ms_cnt <= ms_base;
        end
    end

endmodule

// File: rtl/btn_gesture.sv
// Turns a debounced button level into short / long / repeat / double-click
// single-cycle events, plus a registered "held" indication.
module btn_gesture #(
    parameter int unsigned CLK_HZ    = board_pkg::CLK_HZ,
    parameter int unsigned LONG_MS   = 600,
    parameter int unsigned DCLICK_MS = 250,
    parameter int unsigned REPEAT_MS = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic held,
    output logic short_tick,
    output logic long_tick,
    output logic repeat_tick,
    output logic double_tick
);
    import board_pkg::*;

    localparam int unsigned  W        = $clog2(max3(LONG_MS, DCLICK_MS, REPEAT_MS) + 1);
    localparam logic [W-1:0] LONG_T   = W'(LONG_MS);
    localparam logic [W-1:0] DCLICK_T = W'(DCLICK_MS);
    localparam logic [W-1:0] REPEAT_T = W'(REPEAT_MS);

    typedef enum logic [2:0] {
        ARM       = 3'd0,
        IDLE      = 3'd1,
        PRESS1    = 3'd2,
        GAP       = 3'd3,
        PRESS2    = 3'd4,
        LONG_HOLD = 3'd5
    } state_t;

    state_t       state;
    state_t       next_state;
    logic         nxt_short;
    logic         nxt_long;
    logic         nxt_repeat;
    logic         nxt_double;
    logic         clr;
    logic [W-1:0] ms_cnt;

    ms_timer #(
        .CLK_HZ (CLK_HZ),
        .W      (W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .ms_cnt (ms_cnt)
    );

    // NOTE: every output of this block is given a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        nxt_short  = 1'b0;
        nxt_long   = 1'b0;
        nxt_repeat = 1'b0;
        nxt_double = 1'b0;
        // Level changes are tested before thresholds so they win a tie.
        case (state)
            ARM: begin
                if (!level) next_state = IDLE;
            end
            IDLE: begin
                if (level) next_state = PRESS1;
            end
            PRESS1: begin
                if (!level) begin
                    next_state = GAP;
                end else if (ms_cnt == LONG_T) begin
                    next_state = LONG_HOLD;
                    nxt_long   = 1'b1;
                end
            end
            GAP: begin
                if (level) begin
                    next_state = PRESS2;
                end else if (ms_cnt == DCLICK_T) begin
                    next_state = IDLE;
                    nxt_short  = 1'b1;
                end
            end
            PRESS2: begin
                if (!level) begin
                    next_state = IDLE;
                    nxt_double = 1'b1;
                end else if (ms_cnt == LONG_T) begin
                    next_state = LONG_HOLD;
                    nxt_long   = 1'b1;
                end
            end
            LONG_HOLD: begin
                if (!level) begin
                    next_state = IDLE;
                end else if (ms_cnt == REPEAT_T) begin
                    nxt_repeat = 1'b1;
                end
            end
            default: begin
                next_state = ARM;
            end
        endcase
    end

    assign clr = (next_state != state) || nxt_repeat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARM;
            held        <= 1'b0;
            short_tick  <= 1'b0;
            long_tick   <= 1'b0;
            repeat_tick <= 1'b0;
            double_tick <= 1'b0;
        end else begin
            state       <= next_state;
            held        <= (next_state == PRESS1) || (next_state == PRESS2) ||
                           (next_state == LONG_HOLD);
            short_tick  <= nxt_short;
            long_tick   <= nxt_long;
            repeat_tick <= nxt_repeat;
            double_tick <= nxt_double;
        end
    end

endmodule

// File: tb/tb_btn_gesture.sv
// Bench for btn_gesture: cycle-age reference model compared every cycle, plus
// directed gesture scenarios with hand-computed event times.
module tb_btn_gesture;

    localparam int unsigned CLK_HZ    = 10_000;
    localparam int unsigned LONG_MS   = 20;
    localparam int unsigned DCLICK_MS = 10;
    localparam int unsigned REPEAT_MS = 5;
    localparam int MS     = 10;
    localparam int LONG_C = 20 * MS;
    localparam int DCLK_C = 10 * MS;
    localparam int REP_C  = 5 * MS;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic level = 1'b0;
    logic held, short_tick, long_tick, repeat_tick, double_tick;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int short_q[$], long_q[$], rep_q[$], dbl_q[$];

    btn_gesture #(
        .CLK_HZ    (CLK_HZ),
        .LONG_MS   (LONG_MS),
        .DCLICK_MS (DCLICK_MS),
        .REPEAT_MS (REPEAT_MS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .level       (level),
        .held        (held),
        .short_tick  (short_tick),
        .long_tick   (long_tick),
        .repeat_tick (repeat_tick),
        .double_tick (double_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: phases of a gesture and the number of cycles spent in
    // the current phase; a rule of N ms triggers once that age reaches N*MS.
    typedef enum int {W_LOW, READY, FIRST, WINDOW, SECOND, REPEATING} phase_t;
    phase_t     ph       = W_LOW;
    int         age      = 0;
    logic [4:0] exp_out  = '0;   // {held, short, long, repeat, double}
    bit         model_on = 1'b0;

    always @(posedge clk) begin
        phase_t     nx;
        logic [3:0] t;
        cyc++;
        t = '0;
        if (rst) begin
            ph       = W_LOW;
            age      = 0;
            model_on = 1'b1;
        end else begin
            age++;
            nx = ph;
            case (ph)
                W_LOW:  if (!level) nx = READY;
                READY:  if (level) nx = FIRST;
                FIRST:  if (!level) nx = WINDOW;
                        else if (age == LONG_C) begin nx = REPEATING; t = 4'b0100; end
                WINDOW: if (level) nx = SECOND;
                        else if (age == DCLK_C) begin nx = READY; t = 4'b1000; end
                SECOND: if (!level) begin nx = READY; t = 4'b0001; end
                        else if (age == LONG_C) begin nx = REPEATING; t = 4'b0100; end
                REPEATING: if (!level) nx = READY;
                        else if (age == REP_C) begin t = 4'b0010; age = 0; end
                default: nx = W_LOW;
            endcase
            if (nx != ph) begin
                ph  = nx;
                age = 0;
            end
        end
        exp_out = {(ph == FIRST) || (ph == SECOND) || (ph == REPEATING), t};
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("outputs", 32'({held, short_tick, long_tick, repeat_tick, double_tick}),
                  32'(exp_out));
            if (short_tick === 1'b1)  short_q.push_back(cyc);
            if (long_tick === 1'b1)   long_q.push_back(cyc);
            if (repeat_tick === 1'b1) rep_q.push_back(cyc);
            if (double_tick === 1'b1) dbl_q.push_back(cyc);
        end
    end

    task automatic clear_q();
        short_q.delete();
        long_q.delete();
        rep_q.delete();
        dbl_q.delete();
    endtask

    // Called at a negedge: level is sampled high/low on the next n posedges.
    task automatic hold(input logic v, input int n);
        level = v;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int   p;
        int   len;
        logic lvl;

        rst   = 1'b1;
        level = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({held, short_tick, long_tick, repeat_tick, double_tick}), 32'd0);
        rst = 1'b0;
        hold(1'b0, 20);

        // 1: short press
        clear_q();
        p = cyc + 1;
        hold(1'b1, 25);
        check("s1_held", 32'(held), 32'd1);
        hold(1'b1, 25);
        hold(1'b0, 150);
        check("s1_short_n", short_q.size(), 1);
        if (short_q.size() > 0) check("s1_short_at", short_q[0], p + 150);
        check("s1_others_n", long_q.size() + rep_q.size() + dbl_q.size(), 0);

        // 2: long hold with auto-repeat
        clear_q();
        p = cyc + 1;
        hold(1'b1, 370);
        hold(1'b0, 150);
        check("s2_long_n", long_q.size(), 1);
        if (long_q.size() > 0) check("s2_long_at", long_q[0], p + 200);
        check("s2_rep_n", rep_q.size(), 3);
        for (int i = 0; i < rep_q.size() && i < 3; i++)
            check("s2_rep_at", rep_q[i], p + 250 + 50 * i);
        check("s2_others_n", short_q.size() + dbl_q.size(), 0);

        // 3: double click
        clear_q();
        p = cyc + 1;
        hold(1'b1, 30);
        hold(1'b0, 40);
        hold(1'b1, 30);
        hold(1'b0, 200);
        check("s3_double_n", dbl_q.size(), 1);
        if (dbl_q.size() > 0) check("s3_double_at", dbl_q[0], p + 100);
        check("s3_others_n", short_q.size() + long_q.size() + rep_q.size(), 0);

        // 4: second press turns long
        clear_q();
        p = cyc + 1;
        hold(1'b1, 30);
        hold(1'b0, 40);
        hold(1'b1, 220);
        hold(1'b0, 200);
        check("s4_long_n", long_q.size(), 1);
        if (long_q.size() > 0) check("s4_long_at", long_q[0], p + 270);
        check("s4_others_n", short_q.size() + dbl_q.size() + rep_q.size(), 0);

        // 5: reset in the double-click window, button held through reset
        clear_q();
        hold(1'b1, 30);
        hold(1'b0, 20);
        rst   = 1'b1;
        level = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold(1'b1, 300);
        check("s5_quiet_n", short_q.size() + long_q.size() + rep_q.size() + dbl_q.size(), 0);
        check("s5_held", 32'(held), 32'd0);
        hold(1'b0, 20);
        clear_q();
        p = cyc + 1;
        hold(1'b1, 50);
        hold(1'b0, 150);
        check("s5_resume_n", short_q.size(), 1);
        if (short_q.size() > 0) check("s5_resume_at", short_q[0], p + 150);

        // 6: release exactly on the long threshold
        clear_q();
        p = cyc + 1;
        hold(1'b1, LONG_C);
        hold(1'b0, 200);
        check("s6_long_n", long_q.size(), 0);
        check("s6_short_n", short_q.size(), 1);
        if (short_q.size() > 0) check("s6_short_at", short_q[0], p + 300);

        // Randomized segments, weighted toward threshold boundaries.
        lvl = 1'b0;
        for (int i = 0; i < 160; i++) begin
            case ($urandom_range(0, 9))
                0:       len = LONG_C - 1 + int'($urandom_range(0, 2));
                1:       len = DCLK_C - 1 + int'($urandom_range(0, 2));
                2:       len = LONG_C + REP_C * int'($urandom_range(1, 3)) - 1 + int'($urandom_range(0, 2));
                3:       len = int'($urandom_range(1, 3));
                default: len = int'($urandom_range(1, 120));
            endcase
            if ($urandom_range(0, 24) == 0) begin
                rst   = 1'b1;
                level = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst = 1'b0;
            end
            lvl = ~lvl;
            hold(lvl, len);
        end
        hold(1'b0, 300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
